mtf_update_sched: RTL and testbench
===================================

MTF_UPDATE_SCHED -- requirements
Module: mtf_update_sched

Interface
REQ-001 SHALL have parameter N_NEUR, default 4, number of neurons time-multiplexed onto one update engine.
REQ-002 SHALL have parameter IDX_W, default 2, neuron index width; must satisfy 2**IDX_W >= N_NEUR.
REQ-003 SHALL have parameter TICK_DIV, default 1000, clk cycles per integration step; must be >= 4*N_NEUR+4.
REQ-004 SHALL have parameter WD_MAX, default 255, maximum engine wait cycles before timeout.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  tick generation enable.
REQ-008 cfg_we  input  1  i_ext register write strobe.
REQ-009 cfg_addr  input  IDX_W  neuron index for write.
REQ-010 cfg_data  input  8  external current value.
REQ-011 ovr_clr  input  1  clears sticky overrun and fault flags.
REQ-012 eng_start  output  1  one-cycle update request to engine.
REQ-013 eng_idx  output  IDX_W  neuron being updated.
REQ-014 eng_i_ext  output  8  current for neuron eng_idx.
REQ-015 eng_done  input  1  engine completion pulse.
REQ-016 eng_spike  input  1  engine spike result, valid with eng_done.
REQ-017 spike_vec  output  N_NEUR  per-neuron spikes of last completed step.
REQ-018 step_done  output  1  one-cycle pulse when a sweep completes.
REQ-019 busy  output  1  high whenever FSM is not IDLE.
REQ-020 overrun  output  1  sticky: tick arrived while busy.
REQ-021 eng_fault  output  1  sticky: engine timeout occurred.

Function
REQ-022 Tick counter SHALL count 0..TICK_DIV-1 while enable=1, issue a one-cycle internal tick on reaching TICK_DIV-1, and wrap to 0 in that cycle.
REQ-023 enable=0 SHALL clear the tick counter to 0 and suppress ticks; an in-progress sweep SHALL still complete.
REQ-024 FSM states SHALL be IDLE, ISSUE, WAIT, COMMIT.
REQ-025 IDLE: on tick, idx<=0, go to ISSUE.
REQ-026 ISSUE: eng_start=1 for exactly one cycle, eng_idx=idx, eng_i_ext=i_ext[idx] captured into a holding register on entry; go to WAIT with watchdog cleared.
REQ-027 eng_idx and eng_i_ext SHALL remain stable from ISSUE through the end of WAIT.
REQ-028 WAIT: on eng_done, shadow[idx]<=eng_spike; if idx==N_NEUR-1 go to COMMIT, else idx<=idx+1 and go to ISSUE.
REQ-029 WAIT: eng_done in the same cycle as eng_start SHALL be ignored.
REQ-030 WAIT: if the watchdog reaches WD_MAX without eng_done, set eng_fault, shadow[idx]<=0, and advance as if eng_done had been received.
REQ-031 COMMIT: spike_vec<=shadow, step_done=1 for one cycle, go to IDLE.
REQ-032 Minimum sweep latency with a 1-cycle engine SHALL be 2*N_NEUR+1 cycles from the tick to step_done.
REQ-033 A tick while busy=1 SHALL be dropped and set overrun; the current sweep continues unaffected.
REQ-034 cfg_we SHALL write i_ext[cfg_addr]<=cfg_data on the next edge in any state; cfg_addr>=N_NEUR writes SHALL be ignored.
REQ-035 A write to the neuron currently in WAIT SHALL NOT alter eng_i_ext; it takes effect on the next sweep.
REQ-036 ovr_clr SHALL clear overrun and eng_fault; a simultaneous set event SHALL win.

Reset
REQ-037 reset SHALL force IDLE, idx=0, tick counter=0, watchdog=0, all i_ext=0, shadow=0, spike_vec=0, eng_start=0, eng_idx=0, eng_i_ext=0, step_done=0, busy=0, overrun=0, eng_fault=0.
REQ-038 reset asserted mid-sweep SHALL abort the sweep with no step_done; eng_done arriving after reset SHALL be ignored in IDLE.

Verification
REQ-039 TICK_DIV=20, N_NEUR=4, 1-cycle engine, spike pattern 1,0,1,1 -> eng_start at idx 0..3, step_done 9 cycles after tick, spike_vec=4'b1101.
REQ-040 Write cfg_addr=2, cfg_data=0x3C, then tick -> eng_i_ext=0x3C while eng_idx=2, and 0x00 for the other neurons.
REQ-041 Engine stalled on idx 1 -> eng_fault=1 after 255 wait cycles, spike_vec[1]=0, sweep completes; ovr_clr -> eng_fault=0.
REQ-042 Engine latency 10 cycles with TICK_DIV=20 -> second tick arrives busy, overrun=1, and exactly one step_done is produced per completed sweep.
REQ-043 reset during WAIT on idx 2 -> all outputs reach reset values next cycle, no step_done; a later eng_done causes no state change.
REQ-044 enable dropped mid-sweep -> sweep finishes with step_done; no further eng_start until enable returns plus TICK_DIV cycles.

Source files
------------

// File: rtl/mtf_update_sched.sv
// rtl/mtf_update_sched.sv - tick-driven scheduler that sweeps N_NEUR neurons through one shared update engine
module mtf_update_sched #(
  parameter int N_NEUR   = 4,
  parameter int IDX_W    = 2,
  parameter int TICK_DIV = 1000,
  parameter int WD_MAX   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [7:0]        cfg_data,
  input  logic              ovr_clr,
  output logic              eng_start,
  output logic [IDX_W-1:0]  eng_idx,
  output logic [7:0]        eng_i_ext,
  input  logic              eng_done,
  input  logic              eng_spike,
  output logic [N_NEUR-1:0] spike_vec,
  output logic              step_done,
  output logic              busy,
  output logic              overrun,
  output logic              eng_fault
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WD_W  = (WD_MAX > 1) ? $clog2(WD_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEUR - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMMIT
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [WD_W-1:0]     wd_q;
  logic [CNT_W-1:0]    tick_cnt_q;
  logic [CNT_W-1:0]    tick_cnt_d;
  logic                tick;
  logic [7:0]          i_ext_q [N_NEUR];
  logic [N_NEUR-1:0]   shadow_q;
  logic [N_NEUR-1:0]   shadow_d;
  logic [N_NEUR-1:0]   spike_vec_q;
  logic                eng_start_q;
  logic [IDX_W-1:0]    eng_idx_q;
  logic [7:0]          eng_i_ext_q;
  logic                step_done_q;
  logic                busy_q;
  logic                overrun_q;
  logic                eng_fault_q;

  logic                cfg_in_range;
  logic                done_ev;
  logic                timeout;
  logic                advance;
  logic                res_bit;
  logic [IDX_W-1:0]    idx_inc;

  assign cfg_in_range = int'(cfg_addr) < N_NEUR;
  assign idx_inc      = idx_q + 1'b1;

  // A done pulse only counts while waiting; one seen during ISSUE (same cycle as
  // eng_start) is dropped. A timeout retires the neuron as "no spike".
  assign done_ev = (state_q == S_WAIT) && eng_done;
  assign timeout = (state_q == S_WAIT) && !eng_done && (wd_q == WD_LAST);
  assign advance = done_ev || timeout;
  assign res_bit = done_ev ? eng_spike : 1'b0;

  // Free-running step divider: wraps on the tick cycle, held at zero while disabled.
  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = tick_cnt_q;
    if (!enable) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == CNT_LAST) begin
      tick       = 1'b1;
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Per-neuron external current table; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEUR; i++) begin
        i_ext_q[i] <= '0;
      end
    end else if (cfg_we && cfg_in_range) begin
      i_ext_q[cfg_addr] <= cfg_data;
    end
  end

  // Shadow spike vector with the result of the neuron being retired this cycle merged in.
  always_comb begin
    shadow_d = shadow_q;
    if (advance) begin
      shadow_d[idx_q] = res_bit;
    end
  end

  // Sweep sequencer. eng_idx/eng_i_ext are loaded only when entering ISSUE, so
  // table writes during WAIT cannot disturb the value the engine is using.
  // spike_vec is loaded on the edge into COMMIT so it is valid alongside step_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wd_q        <= '0;
      shadow_q    <= '0;
      spike_vec_q <= '0;
      eng_start_q <= 1'b0;
      eng_idx_q   <= '0;
      eng_i_ext_q <= '0;
      step_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      step_done_q <= 1'b0;
      shadow_q    <= shadow_d;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            idx_q       <= '0;
            eng_idx_q   <= '0;
            eng_i_ext_q <= i_ext_q[0];
            eng_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (advance) begin
            if (idx_q == IDX_LAST) begin
              spike_vec_q <= shadow_d;
              step_done_q <= 1'b1;
              state_q     <= S_COMMIT;
            end else begin
              idx_q       <= idx_inc;
              eng_idx_q   <= idx_inc;
              eng_i_ext_q <= i_ext_q[idx_inc];
              eng_start_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_COMMIT: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky status flags; a set event in the same cycle as ovr_clr wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      eng_fault_q <= 1'b0;
    end else begin
      if (tick && busy_q) begin
        overrun_q <= 1'b1;
      end else if (ovr_clr) begin
        overrun_q <= 1'b0;
      end
      if (timeout) begin
        eng_fault_q <= 1'b1;
      end else if (ovr_clr) begin
        eng_fault_q <= 1'b0;
      end
    end
  end

  assign eng_start = eng_start_q;
  assign eng_idx   = eng_idx_q;
  assign eng_i_ext = eng_i_ext_q;
  assign spike_vec = spike_vec_q;
  assign step_done = step_done_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign eng_fault = eng_fault_q;

endmodule

// File: tb/tb_mtf_update_sched.sv
// tb/tb_mtf_update_sched.sv - self-checking bench for mtf_update_sched
module tb_mtf_update_sched;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TD = 20;
  localparam int WD = 255;

  logic          clk = 1'b0;
  logic          reset, enable, cfg_we, ovr_clr, eng_done, eng_spike;
  logic [IW-1:0] cfg_addr;
  logic [7:0]    cfg_data;
  logic          eng_start, step_done, busy, overrun, eng_fault;
  logic [IW-1:0] eng_idx;
  logic [7:0]    eng_i_ext;
  logic [N-1:0]  spike_vec;

  always #5 clk = ~clk;

  mtf_update_sched #(.N_NEUR(N), .IDX_W(IW), .TICK_DIV(TD), .WD_MAX(WD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ovr_clr(ovr_clr), .eng_start(eng_start), .eng_idx(eng_idx),
    .eng_i_ext(eng_i_ext), .eng_done(eng_done), .eng_spike(eng_spike),
    .spike_vec(spike_vec), .step_done(step_done), .busy(busy), .overrun(overrun),
    .eng_fault(eng_fault)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural engine: answers eng_start after e_lat cycles, never answers e_stall.
  int         e_lat = 1;
  int         e_stall = -1;
  logic [N-1:0] e_pat = '0;
  bit         e_early = 0;
  int         pend = 0;
  logic       pend_spk = 1'b0;
  logic [7:0] seen_iext [N];

  task automatic engine_step();
    eng_done  = 1'b0;
    eng_spike = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        eng_done  = 1'b1;
        eng_spike = pend_spk;
      end
    end
    if (eng_start) begin
      seen_iext[eng_idx] = eng_i_ext;
      if (e_early) begin
        eng_done  = 1'b1;
        eng_spike = ~e_pat[eng_idx];
      end
      if (int'(eng_idx) != e_stall) begin
        pend     = e_lat;
        pend_spk = e_pat[eng_idx];
      end
    end
  endtask

  // Reference model: a sweep is a schedule of start cycles derived from the
  // engine latency of each neuron; the outputs follow from that schedule.
  bit           m_act = 0;
  bit           m_just_rst = 0;
  int           m_t = 0;
  int           m_end = 0;
  int           m_start [N];
  logic [7:0]   m_snap [N];
  logic [7:0]   m_iext [N];
  int           m_cnt = 0;
  bit           m_ovr = 0;
  bit           m_flt = 0;
  logic [N-1:0] m_spk = '0;
  int           s_lat = 1;
  int           s_stall = -1;
  logic [N-1:0] s_pat = '0;

  task automatic model_update();
    int n;
    bit busy_n, tick, oset, fset;
    logic [N-1:0] mask;
    n = cyc;
    if (reset) begin
      m_act = 0; m_cnt = 0; m_ovr = 0; m_flt = 0; m_spk = '0; m_just_rst = 1;
      for (int i = 0; i < N; i++) m_iext[i] = '0;
      return;
    end
    m_just_rst = 0;
    busy_n = m_act && (n >= m_t + 1) && (n <= m_end);
    tick   = enable && (m_cnt == TD - 1);
    if (!enable || tick) m_cnt = 0;
    else m_cnt++;
    oset = tick && busy_n;
    fset = busy_n && (s_stall >= 0) && (n == m_start[s_stall] + WD);
    if (tick && !busy_n) begin
      int acc;
      m_act = 1; m_t = n; s_lat = e_lat; s_stall = e_stall; s_pat = e_pat;
      acc = n + 1;
      for (int k = 0; k < N; k++) begin
        m_start[k] = acc;
        acc += ((k == s_stall) ? WD : s_lat) + 1;
      end
      m_end = acc;
    end
    if (m_act) begin
      for (int k = 0; k < N; k++)
        if (n == m_start[k] - 1) m_snap[k] = m_iext[k];
      if (n + 1 == m_end) begin
        mask = '0;
        if (s_stall >= 0) mask[s_stall] = 1'b1;
        m_spk = s_pat & ~mask;
      end
    end
    m_ovr = oset ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
    m_flt = fset ? 1'b1 : (ovr_clr ? 1'b0 : m_flt);
    if (cfg_we && int'(cfg_addr) < N) m_iext[cfg_addr] = cfg_data;
  endtask

  task automatic check_outputs();
    int c, kk;
    bit exp_st;
    c = cyc;
    exp_st = 0;
    for (int k = 0; k < N; k++) if (m_act && c == m_start[k]) exp_st = 1;
    check("busy", busy, m_act && c >= m_t + 1 && c <= m_end);
    check("step_done", step_done, m_act && c == m_end);
    check("eng_start", eng_start, exp_st);
    check("overrun", overrun, m_ovr);
    check("eng_fault", eng_fault, m_flt);
    check("spike_vec", spike_vec, m_spk);
    if (m_act && c >= m_start[0] && c < m_end) begin
      kk = 0;
      for (int k = 0; k < N; k++) if (c >= m_start[k]) kk = k;
      check("eng_idx", eng_idx, kk);
      check("eng_i_ext", eng_i_ext, m_snap[kk]);
    end
    if (m_just_rst) begin
      check("rst_eng_idx", eng_idx, 0);
      check("rst_eng_i_ext", eng_i_ext, 0);
    end
  endtask

  task automatic step();
    model_update();
    @(negedge clk);
    cyc++;
    check_outputs();
    engine_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_sd(input int maxc, output int when);
    when = -1;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (step_done) begin
        when = cyc;
        break;
      end
    end
    if (when < 0) check("sd_timeout", {31'b0, step_done}, 1);
  endtask

  task automatic wait_idle(input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      if (!(m_act && cyc <= m_end)) break;
      step();
    end
    check("idle_reached", {31'b0, busy && (cyc < m_end)}, 0);
  endtask

  initial begin
    int t, cnt, c0, found;
    reset = 1; enable = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    ovr_clr = 0; eng_done = 0; eng_spike = 0;
    e_pat = 4'b1101; e_lat = 1; e_stall = -1;
    run(3);
    reset = 0;
    run(2);

    // 1-cycle engine, pattern 1,0,1,1
    enable = 1;
    wait_sd(100, t);
    check("lat_1cyc", t - m_t, 9);
    check("spike_1101", spike_vec, 4'b1101);

    // i_ext write reaches only its neuron
    cfg_we = 1; cfg_addr = 2; cfg_data = 8'h3C;
    step();
    cfg_we = 0;
    wait_sd(100, t);
    check("iext_n2", seen_iext[2], 8'h3C);
    check("iext_n0", seen_iext[0], 8'h00);
    check("iext_n3", seen_iext[3], 8'h00);

    // engine stalled on neuron 1
    step();
    e_pat = 4'b1111; e_stall = 1;
    wait_sd(400, t);
    check("fault_set", eng_fault, 1);
    check("spk1_zero", spike_vec[1], 0);
    check("ovr_after_stall", overrun, 1);
    e_stall = -1;
    step();
    ovr_clr = 1;
    step();
    ovr_clr = 0;
    check("fault_clr", eng_fault, 0);
    check("ovr_clr", overrun, 0);

    // 10-cycle engine: sweeps outlast the tick period
    wait_idle(100);
    e_lat = 10; e_pat = 4'b0110;
    wait_sd(200, t);
    check("ovr_lat10", overrun, 1);
    wait_sd(200, t);
    check("spike_lat10", spike_vec, 4'b0110);

    // reset during WAIT on neuron 2
    wait_idle(100);
    e_lat = 5; e_pat = 4'b1011;
    cfg_we = 1; cfg_addr = 1; cfg_data = 8'h55;
    step();
    cfg_we = 0;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (busy && eng_idx == 2 && !eng_start) found = 1;
    end
    check("reach_idx2", found, 1);
    reset = 1;
    step();
    reset = 0; enable = 0;
    check("rst_busy", busy, 0);
    check("rst_spike_vec", spike_vec, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (step_done || busy) cnt++;
    end
    check("no_activity_after_rst", cnt, 0);

    // enable dropped mid-sweep
    e_lat = 3; e_pat = 4'b1001;
    enable = 1;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step();
      if (busy && eng_idx == 1) found = 1;
    end
    check("reach_idx1", found, 1);
    enable = 0;
    wait_sd(100, t);
    check("spike_en_drop", spike_vec, 4'b1001);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (eng_start) cnt++;
    end
    check("no_start_disabled", cnt, 0);
    enable = 1;
    c0 = cyc;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (eng_start) begin
        t = cyc - c0;
        break;
      end
    end
    check("restart_delay", t, TD);

    // done in the same cycle as eng_start is ignored
    wait_idle(100);
    e_early = 1; e_lat = 2; e_pat = 4'b0101;
    wait_sd(100, t);
    check("spike_early", spike_vec, 4'b0101);
    wait_idle(100);
    e_early = 0;

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      wait_idle(400);
      e_lat = $urandom_range(1, 6);
      e_pat = 4'($urandom);
      e_stall = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      for (int i = 0; i < 60; i++) begin
        cfg_we   = ($urandom_range(0, 4) == 0);
        cfg_addr = 2'($urandom);
        cfg_data = 8'($urandom);
        ovr_clr  = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 39) == 0) enable = ~enable;
        step();
      end
      cfg_we = 0; ovr_clr = 0; enable = 1;
    end
    e_stall = -1;
    run(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
